// File: rtl/pll_sample_streamer.sv
// pll_sample_streamer: paced sequential reader of a 1-cycle-latency sample memory with valid/ready output
//   clk_i/reset_n_i      : system clock, async active-low reset
//   start_i/stop_i       : single-cycle playback start / abort pulses
//   loop_en_i            : wrap to word 0 after the last word instead of finishing
//   mem_*_o/mem_readdata_i : memory read port (address, select, clock enable, data a cycle later)
//   sample_*             : captured sample with valid/ready handshake
//   busy_o/done_o        : playback active / one-shot completion pulse
//   late_count_o         : saturating count of sample ticks missed while a sample was held
module pll_sample_streamer #(
  parameter int ADDR_WIDTH      = 18,
  parameter int DATA_WIDTH      = 16,
  parameter int NUM_WORDS       = 240255,
  parameter int CLKS_PER_SAMPLE = 1042
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_en_i,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic                  mem_chipselect_o,
  output logic                  mem_clken_o,
  input  logic [DATA_WIDTH-1:0] mem_readdata_i,
  output logic [DATA_WIDTH-1:0] sample_data_o,
  output logic                  sample_valid_o,
  input  logic                  sample_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           late_count_o
);
  localparam int CW = $clog2(CLKS_PER_SAMPLE);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, HOLD, WAIT_TICK} state_t;
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [15:0]           late_q, late_d;
  logic                  pend_q, cs_q, valid_q, busy_q, done_q;
  logic                  tick, accept, last, go_now;
  always_comb begin
    tick   = busy_q && cnt_q == CW'(CLKS_PER_SAMPLE - 1);
    accept = valid_q && sample_ready_i;
    last   = addr_q == ADDR_WIDTH'(NUM_WORDS - 1);
    go_now = pend_q || tick;
    addr_d = last ? '0 : addr_q + 1'b1;
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    late_d = &late_q ? late_q : late_q + 1'b1;
  end
  // cs_q is set on every transition into FETCH so select/enable are registered, one cycle wide.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      late_q  <= '0;
      pend_q  <= 1'b0;
      cs_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cs_q   <= 1'b0;
      cnt_q  <= cnt_d;
      if (state_q != IDLE && stop_i) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        valid_q <= 1'b0;
        pend_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= '0;
            if (start_i && !stop_i) begin
              addr_q  <= '0;
              pend_q  <= 1'b0;
              late_q  <= '0;
              cs_q    <= 1'b1;
              busy_q  <= 1'b1;
              state_q <= FETCH;
            end
          end
          FETCH: begin
            if (tick) pend_q <= 1'b1;
            state_q <= CAPTURE;
          end
          CAPTURE: begin
            if (tick) pend_q <= 1'b1;
            data_q  <= mem_readdata_i;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
          HOLD: begin
            if (accept) begin
              valid_q <= 1'b0;
              pend_q  <= 1'b0;
              if (last && !loop_en_i) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                cnt_q   <= '0;
                state_q <= IDLE;
              end else begin
                // a tick already pending (or arriving now) starts the next fetch immediately
                addr_q  <= addr_d;
                cs_q    <= go_now;
                state_q <= go_now ? FETCH : WAIT_TICK;
              end
            end else if (tick) begin
              if (pend_q) late_q <= late_d;
              else pend_q <= 1'b1;
            end
          end
          WAIT_TICK: begin
            if (tick) begin
              cs_q    <= 1'b1;
              state_q <= FETCH;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign mem_address_o    = addr_q;
  assign mem_chipselect_o = cs_q;
  assign mem_clken_o      = cs_q;
  assign sample_data_o    = data_q;
  assign sample_valid_o   = valid_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign late_count_o     = late_q;
endmodule

// File: tb/tb_pll_sample_streamer.sv
// tb_pll_sample_streamer: directed self-checking bench for pll_sample_streamer (4 words, 8 clks/sample)
module tb_pll_sample_streamer;
  logic        clk = 1'b0;
  logic        reset_n, start, stop, loop_en, ready;
  logic [17:0] addr;
  logic        cs, ce, valid, busy, done;
  logic [15:0] rdata = 16'h0;
  logic [15:0] data, late;
  int          checks = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  pll_sample_streamer #(
    .ADDR_WIDTH(18), .DATA_WIDTH(16), .NUM_WORDS(4), .CLKS_PER_SAMPLE(8)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .stop_i(stop), .loop_en_i(loop_en),
    .mem_address_o(addr), .mem_chipselect_o(cs), .mem_clken_o(ce), .mem_readdata_i(rdata),
    .sample_data_o(data), .sample_valid_o(valid), .sample_ready_i(ready),
    .busy_o(busy), .done_o(done), .late_count_o(late)
  );
  always_ff @(posedge clk) if (cs && ce) rdata <= 16'hA000 + addr[15:0];
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    ready = 1'b0;
    step(3);
    check("rst_addr", addr, 0);
    check("rst_cs", cs, 0);
    check("rst_ce", ce, 0);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_late", late, 0);
    reset_n = 1'b1;
    step();
    // one-shot, always ready
    ready = 1'b1;
    kick();
    check("os_fetch_cs", cs, 1);
    check("os_fetch_ce", ce, 1);
    check("os_fetch_addr", addr, 0);
    check("os_fetch_busy", busy, 1);
    check("os_fetch_valid", valid, 0);
    step();
    check("os_cap_cs", cs, 0);
    check("os_cap_valid", valid, 0);
    step();
    check("os_v0", valid, 1);
    check("os_d0", data, 16'hA000);
    for (int k = 1; k < 4; k++) begin
      step(7);
      check("os_gap_valid", valid, 0);
      step();
      check("os_valid", valid, 1);
      check("os_data", data, 16'hA000 + k);
      check("os_addr", addr, k);
    end
    step();
    check("os_done", done, 1);
    check("os_end_busy", busy, 0);
    check("os_end_valid", valid, 0);
    step();
    check("os_done_pulse", done, 0);
    // looped playback then stop
    loop_en = 1'b1;
    kick();
    step(2);
    check("lp_d0", data, 16'hA000);
    for (int k = 1; k < 5; k++) begin
      step();
      check("lp_no_done", done, 0);
      check("lp_busy", busy, 1);
      step(6);
      check("lp_gap_valid", valid, 0);
      step();
      check("lp_valid", valid, 1);
      check("lp_data", data, 16'hA000 + (k % 4));
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("lp_stop_valid", valid, 0);
    check("lp_stop_busy", busy, 0);
    check("lp_stop_done", done, 0);
    loop_en = 1'b0;
    // consumer stall
    ready = 1'b0;
    kick();
    step(2);
    check("st_v0", valid, 1);
    step(10);
    check("st_mid_data", data, 16'hA000);
    check("st_mid_valid", valid, 1);
    check("st_mid_late", late, 0);
    step(10);
    check("st_end_data", data, 16'hA000);
    check("st_end_valid", valid, 1);
    check("st_late", late, 1);
    ready = 1'b1;
    step();
    check("st_refetch_cs", cs, 1);
    check("st_refetch_addr", addr, 1);
    check("st_refetch_valid", valid, 0);
    step(2);
    check("st_v1", valid, 1);
    check("st_d1", data, 16'hA001);
    check("st_v1_late", late, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("st_stop_busy", busy, 0);
    check("st_keep_late", late, 1);
    // start+stop in idle, start while busy
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_cs", cs, 0);
    kick();
    check("sb_late_clr", late, 0);
    check("sb_addr0", addr, 0);
    step(5);
    start = 1'b1;
    step();
    start = 1'b0;
    step(2);
    check("sb_fetch_cs", cs, 1);
    check("sb_fetch_addr", addr, 1);
    step(2);
    check("sb_valid", valid, 1);
    check("sb_data", data, 16'hA001);
    step(7);
    ready = 1'b0;
    step();
    check("ar_hold_valid", valid, 1);
    check("ar_hold_data", data, 16'hA002);
    // async reset between edges
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_valid", valid, 0);
    check("ar_busy", busy, 0);
    check("ar_data", data, 0);
    check("ar_addr", addr, 0);
    check("ar_cs", cs, 0);
    reset_n = 1'b1;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
